// File: rtl/seg7_pkg.sv
// Shared types and constants for the adder-result 7-segment display.
// Digit codes are {blank, nibble}; segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = 5;

    localparam logic [CODE_W-1:0] CODE_BLANK = 5'b1_0000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;

    // Element i is the pattern for nibble value i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low segment pattern.
// Latency: combinational. Backpressure: none.
// Blank flag overrides the nibble.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg
);

    assign seg = code[CODE_W-1] ? SEG_BLANK : SEG_TABLE[code[3:0]];

endmodule

// File: rtl/seg7_result_display.sv
// Captures the 5-bit adder result and shows it in decimal or hex on a 4-digit scanned display.
// Latency: display registers update 6 clk after an accepted load; seg/an follow one clk later.
// Backpressure: load is dropped while busy is high; nothing is queued.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CONV_STEPS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] S,
    input  logic       cout,
    input  logic       load,
    input  logic       hex_mode,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       STEP_LAST = 3'(CONV_STEPS - 1);

    state_t      state, state_nxt;
    logic [4:0]  value, value_nxt;
    logic [4:0]  shreg, shreg_nxt;
    logic [7:0]  bcd, bcd_nxt, bcd_adj;
    logic [2:0]  step, step_nxt;
    logic        mode, mode_nxt;
    logic        disp_wr;

    logic [CODE_W-1:0] disp [NUM_DIGITS];
    logic [CODE_W-1:0] disp_new [NUM_DIGITS];
    logic              disp_hex;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [6:0]       dec_seg;

    assign busy    = (state != IDLE);
    assign dp      = 1'b1;
    assign bcd_adj = {dd_adjust(bcd[7:4]), dd_adjust(bcd[3:0])};

    always_comb begin
        state_nxt = state;
        value_nxt = value;
        shreg_nxt = shreg;
        bcd_nxt   = bcd;
        step_nxt  = step;
        mode_nxt  = mode;
        disp_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    value_nxt = {cout, S};
                    shreg_nxt = {cout, S};
                    mode_nxt  = hex_mode;
                    bcd_nxt   = 8'd0;
                    step_nxt  = 3'd0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                {bcd_nxt, shreg_nxt} = {bcd_adj, shreg} << 1;
                step_nxt = step + 3'd1;
                if (step == STEP_LAST) state_nxt = UPDATE;
            end
            UPDATE: begin
                disp_wr   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digit 3 holds a blank code in hex mode; the 'H' is substituted at the output.
    always_comb begin
        disp_new[2] = CODE_BLANK;
        disp_new[3] = CODE_BLANK;
        if (mode) begin
            disp_new[0] = {1'b0, value[3:0]};
            disp_new[1] = value[4] ? {1'b0, 4'h1} : CODE_BLANK;
        end else begin
            disp_new[0] = {1'b0, bcd[3:0]};
            disp_new[1] = (bcd[7:4] == 4'd0) ? CODE_BLANK : {1'b0, bcd[7:4]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            value <= 5'd0;
            shreg <= 5'd0;
            bcd   <= 8'd0;
            step  <= 3'd0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            value <= value_nxt;
            shreg <= shreg_nxt;
            bcd   <= bcd_nxt;
            step  <= step_nxt;
            mode  <= mode_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp[0]  <= {1'b0, 4'h0};
            disp[1]  <= CODE_BLANK;
            disp[2]  <= CODE_BLANK;
            disp[3]  <= CODE_BLANK;
            disp_hex <= 1'b0;
        end else if (disp_wr) begin
            for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= disp_new[i];
            disp_hex <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    seg7_decode u_decode (
        .code (disp[idx]),
        .seg  (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'b1000000;
            an  <= 4'b1110;
        end else begin
            seg <= (disp_hex && idx == 2'd3) ? SEG_H : dec_seg;
            an  <= ~(4'b0001 << idx);
        end
    end

endmodule
